// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution control subsystem.
// Holds the dispatcher state encoding, loop index widths and the channel-group shift helper.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int IDX_W  = 16;
  localparam int KROW_W = 4;
  localparam int IROW_W = 17;

  // Ceiling log2, used to turn ATOMIC_C into a shift amount for channel grouping.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_loop_cnt.sv
// One level of the nested layer loop: counts to a runtime maximum and wraps.
// carry flags the increment that wraps, so levels chain by feeding carry into the next incr.
module conv_loop_cnt
  import conv_ctrl_pkg::*;
#(
  parameter int W = IDX_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         aclken,
  input  logic         clear,
  input  logic         incr,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         carry
);

  assign carry = incr && (count == max);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (aclken) begin
      if (clear) begin
        count <= '0;
      end else if (incr) begin
        count <= carry ? '0 : count + {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/conv_layer_dispatcher.sv
// Layer loop sequencer: walks kernel-group, output-row, kernel-row, channel-group
// and issues one compute command per iteration, then waits for the datapath to drain.
module conv_layer_dispatcher
  import conv_ctrl_pkg::*;
#(
  parameter int  ATOMIC_C  = 4,
  parameter real SIM_DELAY = 1.0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     aclken,
  input  logic                     start,
  input  logic [15:0]              cfg_kgrp_n_m1,
  input  logic [15:0]              cfg_ofmap_h_m1,
  input  logic [15:0]              cfg_ifmap_h_m1,
  input  logic [3:0]               cfg_kernal_h_m1,
  input  logic [15:0]              cfg_chn_n_m1,
  input  logic [1:0]               cfg_stride_m1,
  input  logic [2:0]               cfg_pad_top,
  input  logic                     datapath_idle,
  output logic                     busy,
  output logic                     done,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [IDX_W-1:0]         cmd_kgrp,
  output logic [IDX_W-1:0]         cmd_orow,
  output logic [KROW_W-1:0]        cmd_krow,
  output logic [IDX_W-1:0]         cmd_cgrp,
  output logic signed [IROW_W-1:0] cmd_irow,
  output logic                     cmd_pad,
  output logic                     cmd_first,
  output logic                     cmd_last,
  output logic                     cmd_layer_last
);

  localparam int CSHIFT = log2(ATOMIC_C);

  state_t                    state;
  logic [IDX_W-1:0]          kg_max, oh_max, ih_max, cg_max;
  logic [KROW_W-1:0]         kh_max;
  logic [1:0]                stride_m1;
  logic [2:0]                pad_top;
  logic signed [IROW_W-1:0]  irow_base, irow_raw, stride_step;
  logic                      hs, clear;
  logic                      cgrp_c, krow_c, orow_c, kgrp_c;
  logic                      krow_at_max, cgrp_at_max;

  assign hs    = cmd_valid && cmd_ready && aclken;
  assign clear = (state == IDLE);

  conv_loop_cnt #(.W(IDX_W)) u_cgrp (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .clear(clear),
    .incr(hs), .max(cg_max), .count(cmd_cgrp), .carry(cgrp_c)
  );

  conv_loop_cnt #(.W(KROW_W)) u_krow (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .clear(clear),
    .incr(cgrp_c), .max(kh_max), .count(cmd_krow), .carry(krow_c)
  );

  conv_loop_cnt #(.W(IDX_W)) u_orow (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .clear(clear),
    .incr(krow_c), .max(oh_max), .count(cmd_orow), .carry(orow_c)
  );

  conv_loop_cnt #(.W(IDX_W)) u_kgrp (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .clear(clear),
    .incr(orow_c), .max(kg_max), .count(cmd_kgrp), .carry(kgrp_c)
  );

  // irow_base tracks orow*stride - pad_top, so only the kernel row is added here.
  assign stride_step = $signed({15'b0, stride_m1}) + 17'sd1;
  assign irow_raw    = irow_base + $signed({13'b0, cmd_krow});
  assign krow_at_max = (cmd_krow == kh_max);
  assign cgrp_at_max = (cmd_cgrp == cg_max);

  assign cmd_irow       = cmd_valid ? irow_raw : '0;
  assign cmd_pad        = cmd_valid && (irow_raw[IROW_W-1] || (irow_raw > $signed({1'b0, ih_max})));
  assign cmd_first      = cmd_valid && (cmd_krow == '0) && (cmd_cgrp == '0);
  assign cmd_last       = cmd_valid && krow_at_max && cgrp_at_max;
  assign cmd_layer_last = cmd_last && (cmd_orow == oh_max) && (cmd_kgrp == kg_max);

  // Done is raised one edge after the drained datapath is seen, and busy drops the edge after.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      kg_max    <= '0;
      oh_max    <= '0;
      ih_max    <= '0;
      cg_max    <= '0;
      kh_max    <= '0;
      stride_m1 <= '0;
      pad_top   <= '0;
      irow_base <= '0;
    end else if (aclken) begin
      case (state)
        IDLE: begin
          if (start) begin
            kg_max    <= cfg_kgrp_n_m1;
            oh_max    <= cfg_ofmap_h_m1;
            ih_max    <= cfg_ifmap_h_m1;
            kh_max    <= cfg_kernal_h_m1;
            cg_max    <= cfg_chn_n_m1 >> CSHIFT;
            stride_m1 <= cfg_stride_m1;
            pad_top   <= cfg_pad_top;
            irow_base <= -$signed({14'b0, cfg_pad_top});
            state     <= RUN;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (kgrp_c) begin
            state     <= FLUSH;
            cmd_valid <= 1'b0;
          end
          if (orow_c) begin
            irow_base <= -$signed({14'b0, pad_top});
          end else if (krow_c) begin
            irow_base <= irow_base + stride_step;
          end
        end
        FLUSH: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (datapath_idle) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
